jk_cmd_seq: RTL and testbench

Upstream command sequencer for the team's JK flip-flop stage. Accepts {op, count} commands over a valid/ready interface and buffers them in a small FIFO. Drives registered j/k for exactly count cycles per command, back-to-back with no bubbles, and flags completion. j/k connect directly to the flip-flop's j/k inputs; both blocks share one clock.

---
 rtl/jk_pkg.sv | 10 +
 rtl/jk_cmd_fifo.sv | 44 ++++
 rtl/jk_cmd_seq.sv | 92 +++++++++
 tb/tb_jk_cmd_seq.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/jk_pkg.sv
// jk_pkg: shared op encoding, sequencer state and command record for the JK command path
package jk_pkg;
  localparam int JK_CNT_W = 8;
  typedef enum logic [1:0] {HOLD = 2'b00, RESET = 2'b01, SET = 2'b10, TOGGLE = 2'b11} jk_op_t;
  typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} jk_state_t;
  typedef struct packed {
    jk_op_t              op;
    logic [JK_CNT_W-1:0] cnt;
  } jk_cmd_t;
endpackage

// File: rtl/jk_cmd_fifo.sv
// jk_cmd_fifo: show-ahead synchronous FIFO holding queued JK commands
module jk_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic [AW:0] cnt_q, cnt_d;
  logic wr, rd;
  assign full  = cnt_q == (AW+1)'(DEPTH);
  assign empty = cnt_q == '0;
  assign dout  = mem_q[rp_q];
  always_comb begin
    wr    = push & ~full;
    rd    = pop & ~empty;
    wp_d  = wp_q + AW'(wr);
    rp_d  = rp_q + AW'(rd);
    cnt_d = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) mem_q[wp_q] <= din;
  end
endmodule

// File: rtl/jk_cmd_seq.sv
// jk_cmd_seq: queues {op,count} commands and drives registered j/k back-to-back
// Optional JK_SEQ_SHADOW_EN adds a shadow flip-flop checked against q_fb (sticky mismatch).
module jk_cmd_seq
  import jk_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = JK_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic             j,
  output logic             k,
  output logic             busy,
`ifdef JK_SEQ_SHADOW_EN
  input  logic             q_fb,
  output logic             mismatch,
`endif
  output logic             done
);
  typedef struct packed {
    jk_op_t           op;
    logic [CNT_W-1:0] cnt;
  } cmd_t;
  cmd_t head;
  logic full, empty, load, last, rdy_q;
  jk_state_t state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic j_q, k_q, j_d, k_d, done_q, done_d;
  jk_cmd_fifo #(.DEPTH(DEPTH), .W(2 + CNT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (cmd_valid & cmd_ready),
    .pop   (load),
    .din   ({cmd_op, cmd_cnt}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );
  // rdy_q keeps ready low until the first edge after reset release
  assign cmd_ready = rdy_q & ~full;
  assign busy      = ~empty | (state_q == DRIVE);
  assign j         = j_q;
  assign k         = k_q;
  assign done      = done_q;
  always_comb begin
    last       = (state_q == DRIVE) && (rem_q == '0);
    load       = ~empty && ((state_q == IDLE) || last);
    state_d    = load ? DRIVE : (last ? IDLE : state_q);
    rem_d      = load ? ((head.cnt == '0) ? '0 : head.cnt - CNT_W'(1))
                      : ((state_q == DRIVE && !last) ? rem_q - CNT_W'(1) : rem_q);
    {j_d, k_d} = load ? head.op : ((state_q == DRIVE && !last) ? {j_q, k_q} : 2'b00);
    done_d     = load ? (head.cnt <= CNT_W'(1)) : ((state_q == DRIVE) && (rem_q == CNT_W'(1)));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      j_q     <= 1'b0;
      k_q     <= 1'b0;
      done_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      j_q     <= j_d;
      k_q     <= k_d;
      done_q  <= done_d;
      rdy_q   <= 1'b1;
    end
  end
`ifdef JK_SEQ_SHADOW_EN
  logic sq_q, sq_d, mm_q, mm_d;
  assign mismatch = mm_q;
  always_comb begin
    sq_d = (j_q & k_q) ? ~sq_q : (j_q ? 1'b1 : (k_q ? 1'b0 : sq_q));
    mm_d = mm_q | (rdy_q & (q_fb != sq_q));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq_q <= 1'b0;
      mm_q <= 1'b0;
    end else begin
      sq_q <= sq_d;
      mm_q <= mm_d;
    end
  end
`endif
endmodule

// File: tb/tb_jk_cmd_seq.sv
// tb_jk_cmd_seq: directed vector table plus hand sequences for jk_cmd_seq
module tb_jk_cmd_seq;
  logic clk = 1'b0, rst_n = 1'b0, cmd_valid = 1'b0, cmd_ready, j, k, busy, done;
  logic [1:0] cmd_op = 2'b00;
  logic [7:0] cmd_cnt = 8'd0;
  int n_chk = 0, n_fail = 0;
  logic [1:0] log_q[$];
`ifdef JK_SEQ_SHADOW_EN
  logic q_fb, mismatch, q_ff, force_low = 1'b0;
  assign q_fb = force_low ? 1'b0 : q_ff;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) q_ff <= 1'b0;
    else q_ff <= (j & k) ? ~q_ff : (j ? 1'b1 : (k ? 1'b0 : q_ff));
`endif
  jk_cmd_seq #(.DEPTH(4), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .j         (j),
    .k         (k),
    .busy      (busy),
`ifdef JK_SEQ_SHADOW_EN
    .q_fb      (q_fb),
    .mismatch  (mismatch),
`endif
    .done      (done)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (rst_n && done) log_q.push_back({j, k});
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end
  typedef struct packed {
    logic       v;
    logic [1:0] op;
    logic [7:0] cnt;
    logic [4:0] exp;
  } vec_t;
  vec_t tbl[14];
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic [1:0] op, input logic [7:0] cnt);
    int t = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    while (!cmd_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("push accepted", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask
  task automatic wait_idle(input int lim);
    int t = 0;
    @(negedge clk);
    while (busy && t < lim) begin
      @(negedge clk);
      t++;
    end
    check("reach idle", busy, 0);
  endtask
  initial begin
    int n11;
    logic [1:0] exp_ord[6];
    // exp = {j, k, done, busy, cmd_ready} observed just after the edge that samples the row
    tbl[0]  = '{1'b1, 2'b10, 8'd3, 5'b00011};
    tbl[1]  = '{1'b0, 2'b00, 8'd0, 5'b10011};
    tbl[2]  = '{1'b0, 2'b00, 8'd0, 5'b10011};
    tbl[3]  = '{1'b0, 2'b00, 8'd0, 5'b10111};
    tbl[4]  = '{1'b0, 2'b00, 8'd0, 5'b00001};
    tbl[5]  = '{1'b1, 2'b01, 8'd1, 5'b00011};
    tbl[6]  = '{1'b1, 2'b11, 8'd2, 5'b01111};
    tbl[7]  = '{1'b0, 2'b00, 8'd0, 5'b11011};
    tbl[8]  = '{1'b0, 2'b00, 8'd0, 5'b11111};
    tbl[9]  = '{1'b0, 2'b00, 8'd0, 5'b00001};
    tbl[10] = '{1'b1, 2'b11, 8'd0, 5'b00011};
    tbl[11] = '{1'b0, 2'b00, 8'd0, 5'b11111};
    tbl[12] = '{1'b0, 2'b00, 8'd0, 5'b00001};
    tbl[13] = '{1'b0, 2'b00, 8'd0, 5'b00001};
    exp_ord = '{2'b10, 2'b01, 2'b11, 2'b00, 2'b10, 2'b01};
    repeat (3) @(posedge clk);
    #1 check("reset outputs", {j, k, done, busy, cmd_ready}, 0);
    @(negedge clk) rst_n = 1'b1;
    check("ready low before first edge", cmd_ready, 0);
    @(posedge clk);
    #1 check("ready after release", cmd_ready, 1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cmd_valid = tbl[i].v;
      cmd_op    = tbl[i].op;
      cmd_cnt   = tbl[i].cnt;
      @(posedge clk);
      #1 check($sformatf("vec%0d jk_done_busy_rdy", i), {j, k, done, busy, cmd_ready}, tbl[i].exp);
    end
    cmd_valid = 1'b0;
    log_q.delete();
    push(2'b10, 8'd10);
    push(2'b01, 8'd2);
    push(2'b11, 8'd1);
    push(2'b00, 8'd1);
    push(2'b10, 8'd3);
    check("ready low when full", cmd_ready, 0);
    push(2'b01, 8'd1);
    wait_idle(300);
    check("done count in order test", log_q.size(), 6);
    for (int i = 0; i < 6 && i < log_q.size(); i++)
      check($sformatf("issue order %0d", i), log_q[i], exp_ord[i]);
    push(2'b10, 8'd5);
    push(2'b01, 8'd1);
    push(2'b11, 8'd1);
    @(negedge clk);
    check("busy before abort", busy, 1);
    rst_n = 1'b0;
    #1 check("abort outputs", {j, k, done, busy, cmd_ready}, 0);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("no stale cmd %0d", i), {j, k, done, busy}, 0);
    end
    log_q.delete();
    n11 = 0;
    push(2'b11, 8'd255);
    for (int t = 0; t < 400 && busy; t++) begin
      @(negedge clk);
      if (j && k) n11++;
    end
    check("max count drive cycles", n11, 255);
    check("max count done pulses", log_q.size(), 1);
`ifdef JK_SEQ_SHADOW_EN
    push(2'b10, 8'd1);
    push(2'b11, 8'd3);
    wait_idle(50);
    check("shadow tracks ff", mismatch, 0);
    push(2'b10, 8'd1);
    wait_idle(50);
    force_low = 1'b1;
    @(posedge clk);
    #1 force_low = 1'b0;
    check("mismatch set", mismatch, 1);
    repeat (3) @(posedge clk);
    #1 check("mismatch sticky", mismatch, 1);
    @(negedge clk) rst_n = 1'b0;
    #1 check("mismatch cleared", mismatch, 0);
    @(negedge clk) rst_n = 1'b1;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
